countdown_timer: RTL
====================

// Module: countdown_timer
// PURPOSE
//  Two-digit BCD countdown timer (order/cook timer) fed by the slow divided clock from
//  the adjustable clock divider. Syncs slow_clk into the clk_in domain and turns each
//  rising edge into a one-cycle tick. On each tick it decrements the time by one unit.
//  Drives the 7-seg digit decoders and flags expiry to the game controller.
// PARAMETERS
//  DEFAULT_BCD  8'h60  value loaded on reset, or when load_val is not valid BCD
//  SYNC_STAGES  2      flops before the edge-detect flop (minimum 2)
// PORTS
//  clk_in    in   1  system clock; every flop uses this clock
//  reset     in   1  asynchronous, active-low reset
//  slow_clk  in   1  divided clock from the divider; asynchronous to clk_in
//  start     in   1  1-cycle pulse: load load_val, then start counting
//  pause     in   1  1-cycle pulse: toggle between RUN and PAUSE
//  clear     in   1  1-cycle pulse: return to IDLE
//  load_val  in   8  start time in BCD, {tens[7:4], ones[3:0]}
//  tens      out  4  current tens digit, BCD
//  ones      out  4  current ones digit, BCD
//  state     out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
//  running   out  1  1 only in RUN
//  alarm     out  1  1 only in DONE (level)
//  expired   out  1  1-cycle pulse on entry to DONE
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, {tens,ones}=DEFAULT_BCD, running=0, alarm=0,
//   expired=0, all sync/edge flops=0. Outputs take these values immediately, without a clock edge.
//  Tick: slow_clk passes through SYNC_STAGES flops, then an edge flop.
//   tick = synced & ~edge_flop. Tick fires 2-3 clk_in cycles after slow_clk rises.
//   Exactly one tick per slow_clk rising edge. Falling edges are ignored.
//  Load value: if either nibble of load_val > 9, DEFAULT_BCD is loaded instead.
//  Decrement on tick (BCD):
//   - ones != 0: ones -= 1.
//   - ones == 0 and tens != 0: ones = 9, tens -= 1.
//   - The counter never wraps below 00.
//  FSM, evaluated each clk_in edge. Priority: start > clear > pause > tick.
//   IDLE : start -> load, RUN. Other inputs are ignored. Digits hold.
//   RUN  : start -> reload, stay in RUN.
//          clear -> IDLE, digits = DEFAULT_BCD.
//          pause -> PAUSE.
//          tick -> decrement. If the result is 00: -> DONE, expired=1 for that cycle.
//   PAUSE: ticks are dropped, not queued.
//          pause -> RUN. start -> reload, RUN. clear -> IDLE, digits = DEFAULT_BCD.
//   DONE : digits hold 00, alarm=1.
//          start -> reload, RUN. clear -> IDLE, digits = DEFAULT_BCD. pause is ignored.
//  Start with a loaded value of 00: go to RUN, then DONE on the next clk_in edge.
//   expired pulses on that cycle; no tick is needed.
//  Simultaneous events:
//   - start and tick in the same cycle: load wins, and the tick is consumed.
//   - pause and tick in RUN: go to PAUSE, no decrement.
//  All outputs are registered. Digits update on the clk_in edge after the tick cycle.
//  expired is high for exactly one clk_in cycle per entry to DONE.
//  Reset asserted mid-count: everything returns to reset values. There is no resume.
// TESTING
//  1 Deassert reset, pulse start with load_val=8'h03, run slow_clk
//    -> digits go 03,02,01,00; DONE; expired pulses once; alarm=1.
//  2 load 8'h10, start, one tick -> digits 09 (BCD borrow), state RUN.
//  3 RUN at 8'h25, pulse pause, apply 3 slow_clk edges, pulse pause, apply 1 edge
//    -> 25 held while paused, then 24.
//  4 load_val=8'h7A, start -> digits 60 (DEFAULT_BCD).
//    load_val=8'h00, start -> DONE next cycle, expired=1.
//  5 start and tick in the same cycle at 8'h05 -> digits 05 (reload wins).
//    clear in DONE -> IDLE, digits 60.
//  6 Drop reset mid-count at 8'h42 -> IDLE, digits 60, running=0 with no clock edge.
//    Release reset; a slow_clk edge -> no change.

Source files
------------

// File: rtl/countdown_timer_if.sv
// Signal bundle between the countdown timer and its surroundings:
// control pulses and the slow clock in, BCD digits and status out.
interface countdown_timer_if;
    logic       slow_clk;
    logic       start;
    logic       pause;
    logic       clear;
    logic [7:0] load_val;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [1:0] state;
    logic       running;
    logic       alarm;
    logic       expired;

    modport master (
        output slow_clk, start, pause, clear, load_val,
        input  tens, ones, state, running, alarm, expired
    );

    modport slave (
        input  slow_clk, start, pause, clear, load_val,
        output tens, ones, state, running, alarm, expired
    );
endinterface

// File: rtl/countdown_timer.sv
// Two-digit BCD countdown timer, decremented once per rising edge of the
// asynchronous slow clock; reports expiry as a level (alarm) and a pulse (expired).
//
//   state | meaning
//   IDLE  | holding digits, waiting for start
//   RUN   | counting down one unit per slow_clk tick
//   PAUSE | digits frozen, ticks dropped
//   DONE  | reached 00, alarm asserted until start or clear
module countdown_timer #(
    parameter logic [7:0] DEFAULT_BCD = 8'h60,
    parameter int         SYNC_STAGES = 2
) (
    input  logic               clk_in,
    input  logic               reset,
    countdown_timer_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              tens_q, tens_d;
    logic [3:0]              ones_q, ones_d;
    logic                    expired_q, expired_d;
    logic                    running_q, running_d;
    logic                    alarm_q, alarm_d;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    edge_q;
    logic                    tick;
    logic [7:0]              load_bcd;
    logic [7:0]              dec_bcd;

    assign tick = sync_q[SYNC_STAGES-1] & ~edge_q;

    // Out-of-range nibbles fall back to the default time
    assign load_bcd = (bus.load_val[7:4] <= 4'd9 && bus.load_val[3:0] <= 4'd9)
                      ? bus.load_val : DEFAULT_BCD;

    always_comb begin
        dec_bcd = {tens_q, ones_q};
        if (ones_q != 4'd0) begin
            dec_bcd[3:0] = ones_q - 4'd1;
        end else if (tens_q != 4'd0) begin
            dec_bcd = {tens_q - 4'd1, 4'd9};
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            sync_q    <= '0;
            edge_q    <= 1'b0;
            state_q   <= IDLE;
            tens_q    <= DEFAULT_BCD[7:4];
            ones_q    <= DEFAULT_BCD[3:0];
            expired_q <= 1'b0;
            running_q <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], bus.slow_clk};
            edge_q    <= sync_q[SYNC_STAGES-1];
            state_q   <= state_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            expired_q <= expired_d;
            running_q <= running_d;
            alarm_q   <= alarm_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tens_d    = tens_q;
        ones_d    = ones_q;
        expired_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    {tens_d, ones_d} = load_bcd;
                    state_d          = RUN;
                end
            end
            RUN: begin
                if (bus.start) begin
                    {tens_d, ones_d} = load_bcd;
                end else if (bus.clear) begin
                    {tens_d, ones_d} = DEFAULT_BCD;
                    state_d          = IDLE;
                end else if (bus.pause) begin
                    state_d = PAUSE;
                end else if ({tens_q, ones_q} == 8'h00) begin
                    // A start with 00 expires on the following edge without a tick
                    state_d   = DONE;
                    expired_d = 1'b1;
                end else if (tick) begin
                    {tens_d, ones_d} = dec_bcd;
                    if (dec_bcd == 8'h00) begin
                        state_d   = DONE;
                        expired_d = 1'b1;
                    end
                end
            end
            PAUSE: begin
                if (bus.start) begin
                    {tens_d, ones_d} = load_bcd;
                    state_d          = RUN;
                end else if (bus.clear) begin
                    {tens_d, ones_d} = DEFAULT_BCD;
                    state_d          = IDLE;
                end else if (bus.pause) begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (bus.start) begin
                    {tens_d, ones_d} = load_bcd;
                    state_d          = RUN;
                end else if (bus.clear) begin
                    {tens_d, ones_d} = DEFAULT_BCD;
                    state_d          = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        running_d = (state_d == RUN);
        alarm_d   = (state_d == DONE);
    end

    assign bus.tens    = tens_q;
    assign bus.ones    = ones_q;
    assign bus.state   = state_q;
    assign bus.running = running_q;
    assign bus.alarm   = alarm_q;
    assign bus.expired = expired_q;

endmodule
